// File: rtl/vga_mono_scanout_if.sv
// Framebuffer read port plus monochrome video output bundle for vga_mono_scanout.
// master = scanout engine, slave = RAM/video environment.
interface vga_mono_scanout_if #(
  parameter int width   = 8,
  parameter int widthad = 15
);
  logic               enable;
  logic [widthad-1:0] base_addr;
  logic [widthad-1:0] address_b;
  logic [width-1:0]   q_b;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic               pixel;
  logic               frame_start;

  modport master (
    input  enable, base_addr, q_b,
    output address_b, hsync, vsync, de, pixel, frame_start
  );

  modport slave (
    output enable, base_addr, q_b,
    input  address_b, hsync, vsync, de, pixel, frame_start
  );
endinterface

// File: rtl/vga_mono_scanout.sv
// VGA timing + framebuffer read engine: fetches width-pixel words and serialises them
// to 1bpp pixels, with sync/de/frame_start delayed to match the 3-cycle data path.
module vga_mono_scanout #(
  parameter int width    = 8,
  parameter int widthad  = 15,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                clk,
  input  logic                rst,
  vga_mono_scanout_if.master  bus
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] C_WIDTH    = HW'(width);
  localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOT - 1);
  localparam logic [widthad-1:0] C_LINE_STEP = widthad'(H_ACTIVE / width);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
    logic ld;
  } pipe_t;

  logic [HW-1:0]      r_h_cnt;
  logic [VW-1:0]      r_v_cnt;
  logic [widthad-1:0] r_line_base;
  logic [widthad-1:0] r_address_b;
  logic               r_en_f;
  pipe_t              r_p1, r_p2;
  logic [width-1:0]   r_shift;
  logic               r_hsync, r_vsync, r_de, r_pixel, r_frame_start;

  logic               w_act0, w_hs0, w_vs0, w_fs0, w_fetch0;
  logic [widthad-1:0] w_base0;
  logic [widthad-1:0] w_word0;
  logic [width-1:0]   w_src;

  always_comb begin
    w_act0   = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
    w_hs0    = (r_h_cnt >= C_HS_BEG) && (r_h_cnt <= C_HS_END);
    w_vs0    = (r_v_cnt >= C_VS_BEG) && (r_v_cnt <= C_VS_END);
    w_fs0    = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_fetch0 = w_act0 && ((r_h_cnt % C_WIDTH) == '0);
    // Pixel (0,0) is fetched on the very edge that latches base_addr, so bypass the latch.
    w_base0  = w_fs0 ? bus.base_addr : r_line_base;
    w_word0  = widthad'(r_h_cnt / C_WIDTH);
    w_src    = r_p2.ld ? bus.q_b : {r_shift[width-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_f      <= 1'b0;
      r_line_base <= '0;
      r_address_b <= '0;
    end else begin
      if (w_fs0) begin
        r_en_f      <= bus.enable;
        r_line_base <= bus.base_addr;
      end else if ((r_h_cnt == C_H_LAST) && (r_v_cnt < C_V_ACT)) begin
        r_line_base <= r_line_base + C_LINE_STEP;
      end
      if (w_fetch0) r_address_b <= w_base0 + w_word0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1          <= '0;
      r_p2          <= '0;
      r_shift       <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_pixel       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_p1          <= '{act: w_act0, hs: w_hs0, vs: w_vs0, fs: w_fs0, ld: w_fetch0};
      r_p2          <= r_p1;
      r_shift       <= w_src;
      r_hsync       <= ~r_p2.hs;
      r_vsync       <= ~r_p2.vs;
      r_de          <= r_p2.act;
      r_pixel       <= r_p2.act & r_en_f & w_src[width-1];
      r_frame_start <= r_p2.fs;
    end
  end

  assign bus.address_b   = r_address_b;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.de          = r_de;
  assign bus.pixel       = r_pixel;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_mono_scanout.sv
// Directed bench for vga_mono_scanout on a reduced 144x12 raster with a positional
// reference model of the expected video stream and read addresses.
module tb_vga_mono_scanout;
  localparam int W   = 8;
  localparam int AW  = 15;
  localparam int HA  = 128;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FR  = HT * VT;
  localparam int WPL = HA / W;

  logic clk;
  logic rst;

  vga_mono_scanout_if #(.width(W), .widthad(AW)) bus ();

  vga_mono_scanout #(
    .width(W), .widthad(AW),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] mem [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.q_b <= mem[bus.address_b];

  int total = 0;
  int bad   = 0;

  // Model state: g_e = index of the last clock edge since reset release.
  int          g_e;
  logic        pend_en, cur_en;
  logic [AW-1:0] pend_base, cur_base, exp_addr;

  task automatic tick();
    int n, h, v;
    n = g_e + 1;
    if (n % FR == 0) begin
      pend_en   = bus.enable;
      pend_base = bus.base_addr;
    end
    h = (n % FR) % HT;
    v = (n % FR) / HT;
    if (h < HA && v < VA && (h % W) == 0) exp_addr = pend_base + AW'(v * WPL + h / W);
    @(posedge clk);
    #1;
    g_e = n;
    if (g_e >= 2 && ((g_e - 2) % FR) == 0) begin
      cur_en   = pend_en;
      cur_base = pend_base;
    end
  endtask

  function automatic logic [AW+4:0] exp_vec();
    int p, h, v;
    logic de, hs, vs, fs, px;
    logic [W-1:0] wd;
    if (g_e < 2) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr};
    p  = (g_e - 2) % FR;
    h  = p % HT;
    v  = p / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HFP) && (h < HA + HFP + HS);
    vs = (v >= VA + VFP) && (v < VA + VFP + VS);
    fs = (p == 0);
    wd = mem[cur_base + AW'(v * WPL + h / W)];
    px = de && cur_en && wd[W-1-(h%W)];
    return {!hs, !vs, de, px, fs, exp_addr};
  endfunction

  function automatic logic [AW+4:0] obs_vec();
    return {bus.hsync, bus.vsync, bus.de, bus.pixel, bus.frame_start, bus.address_b};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.base_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = W'(i);
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.hsync !== 1'b1) begin bad++; $display("FAIL rst_hsync got=%b exp=1", bus.hsync); end
    total++; if (bus.vsync !== 1'b1) begin bad++; $display("FAIL rst_vsync got=%b exp=1", bus.vsync); end
    total++; if (bus.de !== 1'b0) begin bad++; $display("FAIL rst_de got=%b exp=0", bus.de); end
    total++; if (bus.pixel !== 1'b0) begin bad++; $display("FAIL rst_pixel got=%b exp=0", bus.pixel); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b exp=0", bus.frame_start); end
    total++; if (bus.address_b !== '0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.address_b); end
    rst = 1'b0;
    g_e = -1; exp_addr = '0; cur_en = 1'b0; pend_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++; if (bus.frame_start !== (g_e == 2)) begin bad++; $display("FAIL first_fs e=%0d got=%b", g_e, bus.frame_start); end
      total++; if (bus.de !== (g_e >= 2)) begin bad++; $display("FAIL first_de e=%0d got=%b", g_e, bus.de); end
      total++; if (bus.address_b !== AW'(g_e < 8 ? 0 : (g_e < 16 ? 1 : 2))) begin
        bad++; $display("FAIL first_addr e=%0d got=%h", g_e, bus.address_b); end
      total++; if (bus.pixel !== (g_e == 17)) begin bad++; $display("FAIL first_pix e=%0d got=%b", g_e, bus.pixel); end
    end
  endtask

  task automatic test_line_frame();
    int de_rise[$], de_fall[$], hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];
    logic pde, phs, pvs;
    pde = bus.de; phs = bus.hsync; pvs = bus.vsync;
    while (g_e < 2 * FR + 20) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL frame_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
      if (g_e == HT) begin
        total++; if (bus.address_b !== AW'(WPL)) begin bad++; $display("FAIL line1_addr got=%h exp=%h", bus.address_b, WPL); end
      end
      if (g_e > HT) begin
        if (bus.de && !pde) de_rise.push_back(g_e);
        if (!bus.de && pde) de_fall.push_back(g_e);
        if (!bus.hsync && phs) hs_fall.push_back(g_e);
        if (bus.hsync && !phs) hs_rise.push_back(g_e);
        if (!bus.vsync && pvs) vs_fall.push_back(g_e);
        if (bus.vsync && !pvs) vs_rise.push_back(g_e);
        if (bus.frame_start) fs_at.push_back(g_e);
      end
      pde = bus.de; phs = bus.hsync; pvs = bus.vsync;
    end
    if (de_rise.size() < 2 || de_fall.size() < 1 || hs_fall.size() < 1 || hs_rise.size() < 1 ||
        vs_fall.size() < 2 || vs_rise.size() < 1 || fs_at.size() < 2) begin
      total++; bad++;
      $display("FAIL timing_events de_r=%0d hs_f=%0d vs_f=%0d fs=%0d", de_rise.size(), hs_fall.size(), vs_fall.size(), fs_at.size());
    end else begin
      total++; if (de_fall[0] - de_rise[0] != HA) begin bad++; $display("FAIL de_len got=%0d exp=%0d", de_fall[0] - de_rise[0], HA); end
      total++; if (de_rise[1] - de_rise[0] != HT) begin bad++; $display("FAIL line_period got=%0d exp=%0d", de_rise[1] - de_rise[0], HT); end
      total++; if (hs_fall[0] - de_rise[0] != HA + HFP) begin bad++; $display("FAIL hs_offset got=%0d exp=%0d", hs_fall[0] - de_rise[0], HA + HFP); end
      total++; if (hs_rise[0] - hs_fall[0] != HS) begin bad++; $display("FAIL hs_len got=%0d exp=%0d", hs_rise[0] - hs_fall[0], HS); end
      total++; if (vs_rise[0] - vs_fall[0] != VS * HT) begin bad++; $display("FAIL vs_len got=%0d exp=%0d", vs_rise[0] - vs_fall[0], VS * HT); end
      total++; if (vs_fall[1] - fs_at[0] != (VA + VFP) * HT) begin bad++; $display("FAIL vs_offset got=%0d exp=%0d", vs_fall[1] - fs_at[0], (VA + VFP) * HT); end
      total++; if (fs_at[1] - fs_at[0] != FR) begin bad++; $display("FAIL fs_period got=%0d exp=%0d", fs_at[1] - fs_at[0], FR); end
    end
  endtask

  task automatic test_wrap_base();
    int fb;
    while ((g_e % FR) != VA * HT + 10) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL pre_wrap_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
    end
    for (int i = 0; i < (1 << AW); i++) mem[i] = '1;
    bus.base_addr = AW'(15'h7FF8);
    fb = g_e - (g_e % FR) + FR;
    while (g_e < fb + FR + 5) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL wrap_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
      if (g_e == fb + 56) begin
        total++; if (bus.address_b !== AW'(15'h7FFF)) begin bad++; $display("FAIL wrap_last got=%h exp=7fff", bus.address_b); end
      end
      if (g_e == fb + 64) begin
        total++; if (bus.address_b !== '0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", bus.address_b); end
      end
      if (g_e == fb + 2 + 64) begin
        total++; if (bus.pixel !== 1'b1) begin bad++; $display("FAIL wrap_pix got=%b exp=1", bus.pixel); end
      end
      if (g_e == fb + 2 * HT + 5) bus.base_addr = AW'(15'h1234);
      if (g_e == fb + 3 * HT) begin
        total++; if (bus.address_b !== AW'(15'h0028)) begin bad++; $display("FAIL midframe_base got=%h exp=0028", bus.address_b); end
      end
      if (g_e == fb + FR) begin
        total++; if (bus.address_b !== AW'(15'h1234)) begin bad++; $display("FAIL next_base got=%h exp=1234", bus.address_b); end
      end
    end
  endtask

  task automatic test_enable();
    int fe;
    fe = g_e - (g_e % FR);
    while (g_e < fe + 2 * FR + 10) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL en_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
      if (g_e == fe + 3 * HT + 7) bus.enable = 1'b0;
      if (g_e == fe + 2 + 4 * HT) begin
        total++; if (bus.pixel !== 1'b1) begin bad++; $display("FAIL en_hold got=%b exp=1", bus.pixel); end
      end
      if (g_e == fe + FR + 2) begin
        total++; if (bus.pixel !== 1'b0 || bus.de !== 1'b1) begin
          bad++; $display("FAIL en_off pix=%b de=%b exp pix=0 de=1", bus.pixel, bus.de); end
      end
      if (g_e == fe + FR + 2 * HT) bus.enable = 1'b1;
      if (g_e == fe + FR + 2 + 4 * HT) begin
        total++; if (bus.pixel !== 1'b0) begin bad++; $display("FAIL en_wait got=%b exp=0", bus.pixel); end
      end
      if (g_e == fe + 2 * FR + 2) begin
        total++; if (bus.pixel !== 1'b1) begin bad++; $display("FAIL en_back got=%b exp=1", bus.pixel); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    while ((g_e % FR) != 3 * HT + 60) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL pre_rst_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
    end
    #2 rst = 1'b1;
    #1;
    total++; if (obs_vec() !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}) begin
      bad++; $display("FAIL async_rst got=%h exp=%h", obs_vec(), {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (obs_vec() !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, AW'(0)}) begin
      bad++; $display("FAIL rst_hold got=%h", obs_vec()); end
    rst = 1'b0;
    g_e = -1; exp_addr = '0; cur_en = 1'b0;
    while (g_e < FR + 10) begin
      tick();
      total++; if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL post_rst_vec e=%0d got=%h exp=%h", g_e, obs_vec(), exp_vec()); end
      if (g_e <= 3) begin
        total++; if (bus.frame_start !== (g_e == 2)) begin bad++; $display("FAIL post_rst_fs e=%0d got=%b", g_e, bus.frame_start); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.base_addr = '0;
    g_e = -1; exp_addr = '0; cur_en = 1'b0; pend_en = 1'b0; pend_base = '0; cur_base = '0;
    test_reset();
    test_line_frame();
    test_wrap_base();
    test_enable();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
